via_timer_bank: RTL and testbench
=================================

Name: via_timer_bank

Overview:
Parametrised multi-channel successor to the VIA timer logic: CHANNELS independent down-counters of WIDTH bits on a byte-wide CPU bus, sharing the VIA phi2 clock-enable scheme (rising/falling strobes).
Each channel supports VIA-compatible one-shot and free-run, external pulse counting, and a new halt-at-zero mode, with optional toggle output.
It serves as the spare timer resource beside the system VIA and drives a combined active-high irq.

Parameters:
CHANNELS, 4, number of timer channels (1..8)
WIDTH, 16, counter/latch width in bits; must be 8, 16, 24 or 32
RESET_VAL, 'h5550, reset value of every latch and counter, truncated to WIDTH

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous reset, active-low
rising  input  1  phi2 rising-edge clock enable
falling  input  1  phi2 falling-edge clock enable
addr  input  4+clog2(CHANNELS)  {channel, reg[3:0]}
wen  input  1  write strobe, qualified by falling
ren  input  1  read strobe, qualified by falling
data_in  input  8  write data
data_out  output  8  registered read data
cnt_i  input  CHANNELS  per-channel external pulse input for count mode
tout  output  CHANNELS  per-channel toggle output
irq_vec  output  CHANNELS  per-channel flag AND enable
irq  output  1  OR of irq_vec

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous and active-low.
- Reset values: latch = count = RESET_VAL; ctrl = 0; flag = 0; armed = 0; reload = 0; tout = all 1; data_out = 0.
- Bus timing: writes and read side-effects occur only when (wen|ren) && falling. data_out is registered on every clock from addr, giving 1-clock latency. Unmapped regs read 0.
- Per-channel register map, NB = WIDTH/8:
  - 0..NB-1: read counter byte i; write latch byte i. Writing byte NB-1 also loads count = {data_in, latch[lower]}, sets armed = 1, clears flag, clears reload, and sets tout = !ctrl[2]. Reading byte 0 clears flag.
  - 4..4+NB-1: latch byte i, read/write, no side-effects.
  - 8: ctrl. [1:0] mode: 00 one-shot, 01 free-run, 10 pulse-count, 11 halt-at-zero. [2] toggle enable. [3] irq enable. [4] run (counter frozen when 0). [7:5] read 0.
  - 9: status. Read gives {7'b0, flag}. Writing 1 to bit 0 clears flag.
- Modes 00/01 (VIA timer 1 behaviour), on each falling while run:
  - If reload is set: count <= latch, reload <= 0. In mode 00, armed <= 0.
  - Otherwise: count <= count-1; if count == 0, reload <= 1.
  - This gives a period of latch+2 falling ticks.
  - Timeout event is raised at the rising strobe while reload && armed. It sets flag and, if ctrl[2], toggles tout.
  - Mode 00 therefore interrupts once per arm but keeps counting. Mode 01 interrupts every period.
- Mode 10:
  - cnt_i is double-synchronised on rising. A falling edge of the synchronised signal enables one decrement at the next falling.
  - When count == 0 and a decrement occurs: timeout if armed, then armed <= 0. Count wraps to all-ones, with no reload.
- Mode 11: decrements each falling until count == 0, then holds 0. The timeout (flag set, tout toggle) fires once at the transition into 0. No reload.
- Priority (same cycle):
  - reset_n > top-byte load > count/reload.
  - For flag: load/clear-by-access > timeout set, except that a status write-1 clear and a timeout in the same cycle leaves flag = 1.
- Width rules: arithmetic is modulo 2^WIDTH. Latch bytes above NB are ignored.
- irq_vec[c] = flag[c] & ctrl[c][3]. irq is combinational from registered state.
- Reset asserted mid-count returns all state to reset values immediately; no event is generated.

Test Plan:
- Reset values: hold reset_n=0 -> irq=0, tout=all 1s, channel 0 count bytes read 50/55 (WIDTH=16).
- Free-run: ch1, ctrl=0x1D, write latch lo=03, hi=00 -> flag set every 5 falling ticks, tout toggles each timeout, irq high until byte-0 read.
- One-shot: ch0, ctrl=0x18, latch 0x0002 -> exactly one flag after 4 falling ticks; no second flag over 20 ticks; counter keeps running (reads latch then decrements).
- Pulse-count: ch2, mode 10, latch 0x0002, 3 falling edges on cnt_i -> flag after 3rd edge; count reads FFFF; further edges set no flag until re-armed.
- Halt-at-zero: ch3, mode 11, latch 0x0004 -> count stops at 0000 for 50 ticks; exactly one flag and one tout toggle.
- Collisions: status write-1 on the same cycle as a timeout -> flag stays 1. Top-byte write on the timeout falling -> count = new value, flag 0. WIDTH=32 build: 4-byte load, period latch+2.

Source files
------------

// File: rtl/via_timer_bank.sv
// Bank of CHANNELS VIA-style down-counters on a byte-wide, phi2-strobed CPU bus.
// Each channel does one-shot, free-run, pulse-count or halt-at-zero counting with a flag, irq enable and toggle output.
module via_timer_bank #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WIDTH     = 16,
  parameter logic [31:0] RESET_VAL = 32'h5550
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        rising,
  input  logic                        falling,
  input  logic [3+$clog2(CHANNELS):0] addr,
  input  logic                        wen,
  input  logic                        ren,
  input  logic [7:0]                  data_in,
  output logic [7:0]                  data_out,
  input  logic [CHANNELS-1:0]         cnt_i,
  output logic [CHANNELS-1:0]         tout,
  output logic [CHANNELS-1:0]         irq_vec,
  output logic                        irq
);
  localparam int unsigned AW = 4 + $clog2(CHANNELS);
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned NB = WIDTH / 8;
  localparam logic [WIDTH-1:0] RST = RESET_VAL[WIDTH-1:0];

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_FREERUN = 2'b01,
    MODE_PULSE   = 2'b10,
    MODE_HALT    = 2'b11
  } mode_e;

  logic [WIDTH-1:0]    r_latch [CHANNELS];
  logic [WIDTH-1:0]    r_count [CHANNELS];
  logic [4:0]          r_ctrl  [CHANNELS];
  logic [CHANNELS-1:0] r_flag, r_armed, r_reload, r_tout;
  logic [CHANNELS-1:0] r_sync1, r_sync2, r_pend;
  logic [7:0]          r_data_out;

  logic [CW-1:0]       w_ch;
  logic [3:0]          w_reg;
  logic                w_we, w_re;
  logic [CHANNELS-1:0] w_hit, w_load, w_rd0, w_stclr, w_to, w_ien;
  logic [WIDTH-1:0]    w_ldval [CHANNELS];
  logic [7:0]          w_rdata;

  if (CHANNELS > 1) begin : g_chsel
    assign w_ch = addr[AW-1:4];
  end else begin : g_chone
    assign w_ch = '0;
  end

  always_comb begin
    w_reg   = addr[3:0];
    w_we    = wen & falling;
    w_re    = ren & falling;
    w_hit   = '0;
    w_load  = '0;
    w_rd0   = '0;
    w_stclr = '0;
    w_to    = '0;
    w_ien   = '0;
    w_rdata = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_hit[c]   = (w_ch == CW'(c));
      w_load[c]  = w_we & w_hit[c] & (w_reg == 4'(NB - 1));
      w_rd0[c]   = w_re & w_hit[c] & (w_reg == 4'd0);
      w_stclr[c] = w_we & w_hit[c] & (w_reg == 4'd9) & data_in[0];
      w_ien[c]   = r_ctrl[c][3];
      w_ldval[c] = r_latch[c];
      w_ldval[c][WIDTH-1 -: 8] = data_in;
      // Modes 00/01 time out on rising while a reload is pending; 10/11 on the decrementing falling.
      case (mode_e'(r_ctrl[c][1:0]))
        MODE_ONESHOT, MODE_FREERUN:
          w_to[c] = rising & r_reload[c] & r_armed[c] & ~w_load[c];
        MODE_PULSE:
          w_to[c] = falling & r_ctrl[c][4] & r_pend[c] & r_armed[c] &
                    (r_count[c] == '0) & ~w_load[c];
        MODE_HALT:
          w_to[c] = falling & r_ctrl[c][4] & (r_count[c] == WIDTH'(1)) & ~w_load[c];
      endcase
      if (w_hit[c]) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (w_reg == 4'(b))     w_rdata = r_count[c][b*8 +: 8];
          if (w_reg == 4'(b + 4)) w_rdata = r_latch[c][b*8 +: 8];
        end
        if (w_reg == 4'd8) w_rdata = {3'b000, r_ctrl[c]};
        if (w_reg == 4'd9) w_rdata = {7'b0000000, r_flag[c]};
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_latch[c] <= RST;
        r_count[c] <= RST;
        r_ctrl[c]  <= '0;
      end
      r_flag     <= '0;
      r_armed    <= '0;
      r_reload   <= '0;
      r_tout     <= '1;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_pend     <= '0;
      r_data_out <= '0;
    end else begin
      r_data_out <= w_rdata;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (w_we && w_hit[c]) begin
          for (int unsigned b = 0; b < NB; b++) begin
            if (w_reg == 4'(b) || w_reg == 4'(b + 4)) r_latch[c][b*8 +: 8] <= data_in;
          end
          if (w_reg == 4'd8) r_ctrl[c] <= data_in[4:0];
        end

        if (w_load[c]) begin
          r_count[c]  <= w_ldval[c];
          r_armed[c]  <= 1'b1;
          r_reload[c] <= 1'b0;
          r_tout[c]   <= ~r_ctrl[c][2];
        end else begin
          if (falling && r_ctrl[c][4]) begin
            case (mode_e'(r_ctrl[c][1:0]))
              MODE_ONESHOT, MODE_FREERUN: begin
                if (r_reload[c]) begin
                  r_count[c]  <= r_latch[c];
                  r_reload[c] <= 1'b0;
                  if (r_ctrl[c][1:0] == MODE_ONESHOT) r_armed[c] <= 1'b0;
                end else begin
                  r_count[c] <= r_count[c] - WIDTH'(1);
                  if (r_count[c] == '0) r_reload[c] <= 1'b1;
                end
              end
              MODE_PULSE: begin
                if (r_pend[c]) begin
                  r_count[c] <= r_count[c] - WIDTH'(1);
                  if (r_count[c] == '0) r_armed[c] <= 1'b0;
                end
              end
              MODE_HALT: begin
                if (r_count[c] != '0) r_count[c] <= r_count[c] - WIDTH'(1);
              end
            endcase
          end
          if (w_to[c] && r_ctrl[c][2]) r_tout[c] <= ~r_tout[c];
        end

        // A status write-1 clear loses to a same-cycle timeout; load and byte-0 read win.
        if (w_load[c] || w_rd0[c]) r_flag[c] <= 1'b0;
        else if (w_to[c])          r_flag[c] <= 1'b1;
        else if (w_stclr[c])       r_flag[c] <= 1'b0;

        if (rising) begin
          r_sync1[c] <= cnt_i[c];
          r_sync2[c] <= r_sync1[c];
        end
        if (rising && r_sync2[c] && !r_sync1[c]) r_pend[c] <= 1'b1;
        else if (falling)                        r_pend[c] <= 1'b0;
      end
    end
  end

  assign data_out = r_data_out;
  assign tout     = r_tout;
  assign irq_vec  = r_flag & w_ien;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_via_timer_bank.sv
// Scoreboard bench for via_timer_bank: a 16-bit bank covers all modes and collisions, a 32-bit bank covers wide loads.
module tb_via_timer_bank;
  logic       clock = 1'b0;
  logic       reset_n, rising, falling, wen, ren, wen32, ren32;
  logic [5:0] addr;
  logic [7:0] data_in, data_out, data_out32;
  logic [3:0] cnt_i, tout, irq_vec, tout32, irq_vec32;
  logic       irq, irq32;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  via_timer_bank #(.CHANNELS(4), .WIDTH(16), .RESET_VAL(32'h5550)) dut (
    .clock(clock), .reset_n(reset_n), .rising(rising), .falling(falling),
    .addr(addr), .wen(wen), .ren(ren), .data_in(data_in), .data_out(data_out),
    .cnt_i(cnt_i), .tout(tout), .irq_vec(irq_vec), .irq(irq));

  via_timer_bank #(.CHANNELS(4), .WIDTH(32), .RESET_VAL(32'h5550)) dut32 (
    .clock(clock), .reset_n(reset_n), .rising(rising), .falling(falling),
    .addr(addr), .wen(wen32), .ren(ren32), .data_in(data_in), .data_out(data_out32),
    .cnt_i(cnt_i), .tout(tout32), .irq_vec(irq_vec32), .irq(irq32));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    if (exp_q.size() != 0) check_eq(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  task automatic exp_sig(input string tag, input logic [31:0] exp, input logic [31:0] got);
    sb_push(tag, exp);
    sb_pop(got);
  endtask

  function automatic logic [5:0] mk(input int unsigned ch, input int unsigned rg);
    return 6'((ch << 4) | rg);
  endfunction

  // One phi2 period: rising strobe, gap, falling strobe carrying the bus cycle, gap.
  task automatic phi2(input logic s32, input logic w, input logic r,
                      input logic [5:0] a, input logic [7:0] d);
    rising = 1'b1;
    @(negedge clock);
    rising = 1'b0;
    @(negedge clock);
    falling = 1'b1;
    addr    = a;
    data_in = d;
    if (s32) begin wen32 = w; ren32 = r; end
    else     begin wen   = w; ren   = r; end
    @(negedge clock);
    falling = 1'b0;
    wen = 1'b0; ren = 1'b0; wen32 = 1'b0; ren32 = 1'b0;
    @(negedge clock);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) phi2(1'b0, 1'b0, 1'b0, addr, 8'h00);
  endtask

  task automatic wr(input logic s32, input int unsigned ch, input int unsigned rg, input logic [7:0] d);
    phi2(s32, 1'b1, 1'b0, mk(ch, rg), d);
  endtask

  task automatic rd(input logic s32, input int unsigned ch, input int unsigned rg,
                    input string tag, input logic [7:0] exp);
    sb_push(tag, {24'h0, exp});
    addr = mk(ch, rg);
    @(negedge clock);
    sb_pop(s32 ? {24'h0, data_out32} : {24'h0, data_out});
  endtask

  task automatic pulse(input int unsigned ch);
    cnt_i[ch] = 1'b0;
    idle(2);
    cnt_i[ch] = 1'b1;
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n_flag;
    int   n_tog;
    logic prev;
    reset_n = 1'b0; rising = 1'b0; falling = 1'b0;
    wen = 1'b0; ren = 1'b0; wen32 = 1'b0; ren32 = 1'b0;
    addr = '0; data_in = '0; cnt_i = '1;
    repeat (3) @(negedge clock);
    exp_sig("rst_irq", 0, irq);
    exp_sig("rst_tout", 4'hF, tout);
    exp_sig("rst_vec", 0, irq_vec);
    exp_sig("rst_dout", 0, data_out);
    exp_sig("rst_irq32", 0, irq32);
    reset_n = 1'b1;
    @(negedge clock);

    rd(0, 0, 0, "rst_cnt_lo", 8'h50);
    rd(0, 0, 1, "rst_cnt_hi", 8'h55);
    rd(0, 0, 5, "rst_latch_hi", 8'h55);
    rd(0, 0, 8, "rst_ctrl", 8'h00);
    rd(0, 0, 9, "rst_stat", 8'h00);
    rd(0, 0, 2, "unmapped_cnt_b2", 8'h00);
    rd(0, 0, 12, "unmapped_reg12", 8'h00);
    rd(1, 0, 1, "rst32_b1", 8'h55);
    rd(1, 0, 3, "rst32_b3", 8'h00);
    wr(0, 0, 6, 8'hAA);
    rd(0, 0, 6, "latch_b2_ignored", 8'h00);
    rd(0, 0, 4, "latch_lo_kept", 8'h50);

    // Free-run, ch1, latch 3: period 5
    wr(0, 1, 8, 8'h1D); wr(0, 1, 0, 8'h03); wr(0, 1, 1, 8'h00);
    exp_sig("fr_tout_load", 0, tout[1]);
    for (int k = 0; k < 4; k++) begin idle(1); exp_sig("fr_irq_quiet", 0, irq); end
    idle(1);
    exp_sig("fr_irq_first", 1, irq);
    exp_sig("fr_vec", 4'b0010, irq_vec);
    exp_sig("fr_tout_tog1", 1, tout[1]);
    rd(0, 1, 0, "fr_cnt_reload", 8'h03);
    phi2(1'b0, 1'b0, 1'b1, mk(1, 0), 8'h00);
    exp_sig("fr_rd_clear", 0, irq);
    idle(3);
    exp_sig("fr_irq_mid", 0, irq);
    idle(1);
    exp_sig("fr_irq_second", 1, irq);
    exp_sig("fr_tout_tog2", 0, tout[1]);
    wr(0, 1, 8, 8'h00); wr(0, 1, 9, 8'h01);
    exp_sig("fr_off", 0, irq);

    // One-shot, ch0, latch 2
    wr(0, 0, 8, 8'h18); wr(0, 0, 0, 8'h02); wr(0, 0, 1, 8'h00);
    idle(3);
    exp_sig("os_quiet", 0, irq);
    rd(0, 0, 1, "os_cnt_wrap_hi", 8'hFF);
    idle(1);
    exp_sig("os_flag", 1, irq);
    rd(0, 0, 0, "os_cnt_reload", 8'h02);
    wr(0, 0, 9, 8'h01);
    exp_sig("os_clear", 0, irq);
    rd(0, 0, 0, "os_cnt_run", 8'h01);
    n_flag = 0;
    for (int k = 0; k < 20; k++) begin idle(1); if (irq) n_flag++; end
    exp_sig("os_no_second", 0, n_flag);
    rd(0, 0, 0, "os_cnt_after", 8'h01);
    exp_sig("os_tout_static", 1, tout[0]);
    wr(0, 0, 8, 8'h00);

    // Pulse count, ch2, latch 2
    wr(0, 2, 8, 8'h1A); wr(0, 2, 0, 8'h02); wr(0, 2, 1, 8'h00);
    pulse(2); pulse(2);
    exp_sig("pc_quiet", 0, irq);
    rd(0, 2, 0, "pc_cnt_zero", 8'h00);
    pulse(2);
    exp_sig("pc_flag", 1, irq);
    rd(0, 2, 0, "pc_wrap_lo", 8'hFF);
    rd(0, 2, 1, "pc_wrap_hi", 8'hFF);
    wr(0, 2, 9, 8'h01);
    pulse(2);
    exp_sig("pc_no_flag", 0, irq);
    rd(0, 2, 0, "pc_cnt_fe", 8'hFE);
    idle(3);
    rd(0, 2, 0, "pc_holds_no_edge", 8'hFE);
    wr(0, 2, 8, 8'h00);

    // Halt-at-zero, ch3, latch 4
    wr(0, 3, 8, 8'h1F); wr(0, 3, 0, 8'h04); wr(0, 3, 1, 8'h00);
    exp_sig("hz_tout_load", 0, tout[3]);
    idle(3);
    exp_sig("hz_quiet", 0, irq);
    rd(0, 3, 0, "hz_cnt_one", 8'h01);
    idle(1);
    exp_sig("hz_flag", 1, irq);
    exp_sig("hz_tout_tog", 1, tout[3]);
    wr(0, 3, 9, 8'h01);
    exp_sig("hz_clear", 0, irq);
    n_flag = 0; n_tog = 0; prev = tout[3];
    for (int k = 0; k < 50; k++) begin
      idle(1);
      if (irq) n_flag++;
      if (tout[3] != prev) n_tog++;
      prev = tout[3];
    end
    exp_sig("hz_no_reflag", 0, n_flag);
    exp_sig("hz_no_retog", 0, n_tog);
    rd(0, 3, 0, "hz_hold_lo", 8'h00);
    rd(0, 3, 1, "hz_hold_hi", 8'h00);

    // Collisions on ch3 (halt mode times out on the falling strobe)
    wr(0, 3, 0, 8'h02); wr(0, 3, 1, 8'h00);
    idle(1);
    wr(0, 3, 9, 8'h01);
    exp_sig("col_stclr_vs_to", 1, irq);
    exp_sig("col_tout_tog", 1, tout[3]);
    wr(0, 3, 9, 8'h01);
    exp_sig("col_clear", 0, irq);
    wr(0, 3, 1, 8'h00);
    idle(1);
    wr(0, 3, 1, 8'h12);
    exp_sig("col_load_flag", 0, irq);
    exp_sig("col_load_tout", 0, tout[3]);
    rd(0, 3, 0, "col_load_lo", 8'h02);
    rd(0, 3, 1, "col_load_hi", 8'h12);
    wr(0, 3, 8, 8'h00);

    // 32-bit bank, ch0 free-run, latch 3
    wr(1, 0, 8, 8'h19); wr(1, 0, 0, 8'h03); wr(1, 0, 1, 8'h00); wr(1, 0, 2, 8'h00); wr(1, 0, 3, 8'h00);
    rd(1, 0, 4, "w32_latch_b0", 8'h03);
    rd(1, 0, 7, "w32_latch_b3", 8'h00);
    idle(3);
    rd(1, 0, 0, "w32_cnt_zero", 8'h00);
    idle(1);
    rd(1, 0, 3, "w32_wrap_b3", 8'hFF);
    exp_sig("w32_quiet", 0, irq32);
    idle(1);
    exp_sig("w32_flag", 1, irq32);
    rd(1, 0, 0, "w32_reload", 8'h03);
    wr(1, 0, 9, 8'h01);
    exp_sig("w32_clear", 0, irq32);
    idle(3);
    exp_sig("w32_mid", 0, irq32);
    idle(1);
    exp_sig("w32_period", 1, irq32);
    exp_sig("w32_main_quiet", 0, irq);

    check_eq("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
